// File: rtl/lif_pkg.sv
// Shared constants for the leaky-integrate-and-fire neuron tile.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package lif_pkg;

  // Width of the membrane potential and of the input current.
  localparam int DATA_W = 8;

  // The threshold is the 4-bit config nibble with this fixed nibble below it.
  localparam logic [3:0] THR_LOW_NIBBLE = 4'hF;

  // Bit positions of the config fields carried on uio_in.
  localparam int TN_LSB = 0;
  localparam int TN_W   = 4;
  localparam int LS_LSB = 4;
  localparam int LS_W   = 3;
  localparam int RE_BIT = 7;

  // Default number of clamped cycles following a spike.
  localparam int DEF_REFRACT_CYCLES = 2;

  // Build the firing threshold from the config nibble: range 15..255.
  function automatic logic [DATA_W-1:0] make_thr(input logic [TN_W-1:0] tn);
    return {tn, THR_LOW_NIBBLE};
  endfunction

endpackage

// File: rtl/lif_integrate.sv
// Leak, integrate and compare datapath for one LIF neuron.
// Latency: purely combinational (0 cycles).
// Backpressure: none; evaluated every cycle, the caller decides whether to commit.
module lif_integrate
  import lif_pkg::*;
(
  input  logic [DATA_W-1:0] u,
  input  logic [DATA_W-1:0] cur,
  input  logic [LS_W-1:0]   ls,
  input  logic [DATA_W-1:0] thr,
  output logic [DATA_W-1:0] s_sat,
  output logic              fire
);

  logic [DATA_W-1:0] leak;
  logic [DATA_W-1:0] leaked;
  logic [DATA_W:0]   sum;

  // Leak term: a zero shift means "no leak", not "leak everything".
  always_comb begin
    leak = '0;
    if (ls != '0) begin
      leak = u >> ls;
    end
  end

  // Integrate one extra bit wide, saturate, then compare against threshold.
  // leak never exceeds u, so the subtraction cannot wrap.
  always_comb begin
    leaked = u - leak;
    sum    = {1'b0, leaked} + {1'b0, cur};
    s_sat  = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    fire   = (s_sat >= thr);
  end

endmodule

// File: rtl/lif_neuron.sv
// TinyTapeout tile: one LIF neuron, spike on uo_out[0], potential on uo_out[7:1].
// Latency: a crossing computed in cycle k shows on uo_out[0] in cycle k+1.
// Backpressure: none; ena=0 freezes potential and refractory count, drops spike.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int REFRACT_CYCLES = DEF_REFRACT_CYCLES,
  parameter int REFRACT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  localparam logic [REFRACT_W-1:0] REFRACT_INIT = REFRACT_W'(REFRACT_CYCLES);
  localparam logic [REFRACT_W-1:0] RCNT_ONE     = REFRACT_W'(1);

  // Registered state.
  logic [DATA_W-1:0]    u_q, u_d;
  logic                 spike_q, spike_d;
  logic [REFRACT_W-1:0] rcnt_q, rcnt_d;

  // Static config decoded straight off the pins; a change applies at the next edge.
  logic [TN_W-1:0]   cfg_tn;
  logic [LS_W-1:0]   cfg_ls;
  logic              cfg_re;
  logic [DATA_W-1:0] thr;

  // Datapath results.
  logic [DATA_W-1:0] s_sat;
  logic              fire;

  assign cfg_tn = uio_in[TN_LSB +: TN_W];
  assign cfg_ls = uio_in[LS_LSB +: LS_W];
  assign cfg_re = uio_in[RE_BIT];
  assign thr    = make_thr(cfg_tn);

  lif_integrate u_integrate (
    .u     (u_q),
    .cur   (ui_in),
    .ls    (cfg_ls),
    .thr   (thr),
    .s_sat (s_sat),
    .fire  (fire)
  );

  // Next-state: refractory clamp beats firing, firing beats plain integration.
  // The spike is a single-cycle pulse, so it defaults low on every edge.
  always_comb begin
    u_d     = u_q;
    spike_d = 1'b0;
    rcnt_d  = rcnt_q;
    if (ena) begin
      if (rcnt_q != '0) begin
        u_d    = '0;
        rcnt_d = rcnt_q - RCNT_ONE;
      end else if (fire) begin
        spike_d = 1'b1;
        u_d     = '0;
        rcnt_d  = cfg_re ? REFRACT_INIT : '0;
      end else begin
        u_d = s_sat;
      end
    end
  end

  // State registers with immediate asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_q     <= '0;
      spike_q <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      u_q     <= u_d;
      spike_q <= spike_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Pin mapping: u[0] is not exposed, bit 0 carries the spike instead.
  assign uo_out  = {u_q[DATA_W-1:1], spike_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron: directed vector table, reset corner
// cases, then randomized traffic against an arithmetic reference model.
module tb_lif_neuron;

  logic       clk;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  int checks;
  int failures;

  lif_neuron #(
    .REFRACT_CYCLES (2),
    .REFRACT_W      (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic [7:0] ui;
    logic [7:0] cfg;
    logic [7:0] exp_uo;
    string      name;
  } vec_t;

  vec_t vecs[$];

  // Reference model state, plain integers.
  int m_u;
  int m_spike;
  int m_rcnt;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_u = 0;
    m_spike = 0;
    m_rcnt = 0;
  endfunction

  // One clock edge of the neuron, straight from the behavioural rules.
  function automatic void model_step(input logic e, input logic [7:0] i, input logic [7:0] cfg);
    int thr, ls, leak, s;
    thr  = int'(cfg[3:0]) * 16 + 15;
    ls   = int'(cfg[6:4]);
    leak = (ls == 0) ? 0 : m_u / (1 << ls);
    s    = m_u - leak + int'(i);
    if (s > 255) s = 255;
    if (!e) begin
      m_spike = 0;
    end else if (m_rcnt > 0) begin
      m_u = 0;
      m_rcnt = m_rcnt - 1;
      m_spike = 0;
    end else if (s >= thr) begin
      m_spike = 1;
      m_u = 0;
      m_rcnt = cfg[7] ? 2 : 0;
    end else begin
      m_spike = 0;
      m_u = s;
    end
  endfunction

  function automatic logic [7:0] model_uo();
    logic [7:0] uv;
    uv = 8'(m_u);
    return {uv[7:1], (m_spike != 0)};
  endfunction

  // Drive inputs just after an edge, take the next edge, sample 1 time unit later.
  task automatic step(input logic e, input logic [7:0] i, input logic [7:0] cfg);
    ena = e;
    ui_in = i;
    uio_in = cfg;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic void add(input logic e, input logic [7:0] i, input logic [7:0] cfg,
                              input logic [7:0] exp, input string name);
    vec_t v;
    v.ena = e; v.ui = i; v.cfg = cfg; v.exp_uo = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    ena = 1'b0;
    ui_in = 8'h00;
    uio_in = 8'h00;
    #2;
    check("reset_uo", uo_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Integrate/fire: THR=63, LS=0, RE=0, I=16 -> period 4
    add(1, 16, 8'h03, 8'h10, "fire_e1");
    add(1, 16, 8'h03, 8'h20, "fire_e2");
    add(1, 16, 8'h03, 8'h30, "fire_e3");
    add(1, 16, 8'h03, 8'h01, "fire_e4");
    add(1, 16, 8'h03, 8'h10, "fire_e5");
    add(1, 16, 8'h03, 8'h20, "fire_e6");
    add(1, 16, 8'h03, 8'h30, "fire_e7");
    add(1, 16, 8'h03, 8'h01, "fire_e8");
    // ena gating: two edges, then five idle edges hold u=32
    add(1, 16, 8'h03, 8'h10, "gate_e1");
    add(1, 16, 8'h03, 8'h20, "gate_e2");
    for (int k = 0; k < 5; k++) add(0, 16, 8'h03, 8'h20, "gate_hold");
    add(1, 16, 8'h03, 8'h30, "gate_e3");
    add(1, 16, 8'h03, 8'h01, "gate_fire");
    // Refractory: THR=63, RE=1, I=64 -> period 3
    add(1, 64, 8'h83, 8'h01, "refr_spk1");
    add(1, 64, 8'h83, 8'h00, "refr_clamp1");
    add(1, 64, 8'h83, 8'h00, "refr_clamp2");
    add(1, 64, 8'h83, 8'h01, "refr_spk2");
    add(1, 64, 8'h83, 8'h00, "refr_clamp3");
    add(1, 64, 8'h83, 8'h00, "refr_clamp4");
    // RE=0: fires every enabled cycle
    add(1, 64, 8'h03, 8'h01, "norefr_1");
    add(1, 64, 8'h03, 8'h01, "norefr_2");
    add(1, 64, 8'h03, 8'h01, "norefr_3");
    // Saturation: THR=255, I=200 -> 200 then 400 clipped to 255 fires
    add(1, 200, 8'h0F, 8'hC8, "sat_e1");
    add(1, 200, 8'h0F, 8'h01, "sat_fire");
    // Leak equilibrium: THR=255, LS=1, I=16 -> 16,24,28,30,31,32,32
    add(1, 16, 8'h1F, 8'h10, "leak_16");
    add(1, 16, 8'h1F, 8'h18, "leak_24");
    add(1, 16, 8'h1F, 8'h1C, "leak_28");
    add(1, 16, 8'h1F, 8'h1E, "leak_30");
    add(1, 16, 8'h1F, 8'h1E, "leak_31");
    add(1, 16, 8'h1F, 8'h20, "leak_32");
    add(1, 16, 8'h1F, 8'h20, "leak_32b");
    // Decay with LS=3, I=0 from 32: 28,25,22,20,18,16,14,13,12,11,10,9,8,7,7
    add(1, 0, 8'h3F, 8'h1C, "decay_28");
    add(1, 0, 8'h3F, 8'h18, "decay_25");
    add(1, 0, 8'h3F, 8'h16, "decay_22");
    add(1, 0, 8'h3F, 8'h14, "decay_20");
    add(1, 0, 8'h3F, 8'h12, "decay_18");
    add(1, 0, 8'h3F, 8'h10, "decay_16");
    add(1, 0, 8'h3F, 8'h0E, "decay_14");
    add(1, 0, 8'h3F, 8'h0C, "decay_13");
    add(1, 0, 8'h3F, 8'h0C, "decay_12");
    add(1, 0, 8'h3F, 8'h0A, "decay_11");
    add(1, 0, 8'h3F, 8'h0A, "decay_10");
    add(1, 0, 8'h3F, 8'h08, "decay_9");
    add(1, 0, 8'h3F, 8'h08, "decay_8");
    add(1, 0, 8'h3F, 8'h06, "decay_7");
    add(1, 0, 8'h3F, 8'h06, "decay_stall");

    foreach (vecs[n]) begin
      step(vecs[n].ena, vecs[n].ui, vecs[n].cfg);
      check(vecs[n].name, uo_out, vecs[n].exp_uo);
      check("uio_oe_zero", uio_oe, 8'h00);
      check("uio_out_zero", uio_out, 8'h00);
    end

    // Async reset mid-clock with u=0x30, no edge in between
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 16, 8'h03);
    check("pre_async_u30", uo_out, 8'h30);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_immediate", uo_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 8'h03);
    check("post_rst_idle1", uo_out, 8'h00);
    step(1, 0, 8'h03);
    check("post_rst_idle2", uo_out, 8'h00);

    // Reset during a spike / refractory window: integration restarts cleanly
    step(1, 64, 8'h83);
    check("pre_rst_spike", uo_out, 8'h01);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_spike", uo_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step(1, 16, 8'h03);
    check("no_refr_after_rst", uo_out, 8'h10);

    // Randomized traffic against the reference model
    do_reset();
    begin
      logic [7:0] cfg;
      logic [7:0] cur;
      logic       e;
      cfg = 8'($urandom);
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 15) == 0) cfg = 8'($urandom);
        e = ($urandom_range(0, 7) != 0);
        case ($urandom_range(0, 2))
          0: cur = 8'($urandom_range(0, 15));
          1: cur = 8'($urandom_range(0, 63));
          default: cur = 8'($urandom);
        endcase
        step(e, cur, cfg);
        model_step(e, cur, cfg);
        check("random", uo_out, model_uo());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
